// File: rtl/e_mdu_pkg.sv
// Shared MDU constants: operation codes used by the control decoder and the
// execute-stage multiply/divide unit, plus default busy-cycle counts.
package e_mdu_pkg;

   typedef enum logic [3:0] {
      MDU_NONE  = 4'd0,
      MDU_MULT  = 4'd1,
      MDU_MULTU = 4'd2,
      MDU_DIV   = 4'd3,
      MDU_DIVU  = 4'd4,
      MDU_MFHI  = 4'd5,
      MDU_MFLO  = 4'd6,
      MDU_MTHI  = 4'd7,
      MDU_MTLO  = 4'd8
   } mdu_op_e;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   function automatic logic is_mult(input logic [3:0] op);
      return (op == MDU_MULT) || (op == MDU_MULTU);
   endfunction

   function automatic logic is_muldiv(input logic [3:0] op);
      return (op == MDU_MULT) || (op == MDU_MULTU) ||
             (op == MDU_DIV)  || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/e_mdu_if.sv
// Execute-stage MDU bus: operation request from E and busy/read result back.
interface e_mdu_if;
   logic        start;
   logic [3:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        stall_req;
   logic [31:0] out;

   modport master (output start, op, a, b, input busy, stall_req, out);
   modport slave  (input start, op, a, b, output busy, stall_req, out);
endinterface

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO; results land in HI/LO when
// the down-counter reaches terminal count.
//   state | meaning
//   IDLE  | cnt_q == 0: accepts mult/div starts and mthi/mtlo writes
//   RUN   | cnt_q != 0: counting down, commits temp HI/LO on 1 -> 0
module e_mdu
   import e_mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic     clk,
   input  logic     reset,
   e_mdu_if.slave   mdu
);

   localparam int MAX_CYC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      hi_q, hi_d, lo_q, lo_d;
   logic [31:0]      thi_q, thi_d, tlo_q, tlo_d;

   logic               accept;
   logic signed [63:0] smul;
   logic [63:0]        umul;
   logic [31:0]        sdiv_b, udiv_b, uquot, urem;
   logic signed [31:0] squot, srem;

   assign accept = mdu.start && (cnt_q == '0) && is_muldiv(mdu.op);

   assign smul = $signed({{32{mdu.a[31]}}, mdu.a}) * $signed({{32{mdu.b[31]}}, mdu.b});
   assign umul = {32'd0, mdu.a} * {32'd0, mdu.b};

   // Divisor is forced to 1 for b==0 (result unused) and for MIN/-1, whose
   // architected answer MIN rem 0 equals MIN/1 and avoids quotient overflow.
   assign sdiv_b = ((mdu.b == 32'd0) ||
                    (mdu.a == 32'h8000_0000 && mdu.b == 32'hFFFF_FFFF)) ? 32'd1 : mdu.b;
   assign udiv_b = (mdu.b == 32'd0) ? 32'd1 : mdu.b;
   assign squot  = $signed(mdu.a) / $signed(sdiv_b);
   assign srem   = $signed(mdu.a) % $signed(sdiv_b);
   assign uquot  = mdu.a / udiv_b;
   assign urem   = mdu.a % udiv_b;

   always_comb begin
      cnt_d = cnt_q;
      hi_d  = hi_q;
      lo_d  = lo_q;
      thi_d = thi_q;
      tlo_d = tlo_q;
      if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) begin
            hi_d = thi_q;
            lo_d = tlo_q;
         end
      end else if (accept) begin
         cnt_d = is_mult(mdu.op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
         case (mdu_op_e'(mdu.op))
            MDU_MULT:  {thi_d, tlo_d} = smul;
            MDU_MULTU: {thi_d, tlo_d} = umul;
            MDU_DIV: begin
               if (mdu.b == 32'd0) {thi_d, tlo_d} = {hi_q, lo_q};
               else                {thi_d, tlo_d} = {srem, squot};
            end
            MDU_DIVU: begin
               if (mdu.b == 32'd0) {thi_d, tlo_d} = {hi_q, lo_q};
               else                {thi_d, tlo_d} = {urem, uquot};
            end
            default: ;
         endcase
      end else if (mdu.op == MDU_MTHI) begin
         hi_d = mdu.a;
      end else if (mdu.op == MDU_MTLO) begin
         lo_d = mdu.a;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         thi_q <= '0;
         tlo_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         thi_q <= thi_d;
         tlo_q <= tlo_d;
      end
   end

   assign mdu.busy      = (cnt_q != '0);
   assign mdu.stall_req = mdu.busy | mdu.start;

   always_comb begin
      mdu.out = 32'd0;
      if (mdu.op == MDU_MFHI)      mdu.out = hi_q;
      else if (mdu.op == MDU_MFLO) mdu.out = lo_q;
   end

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: the driver pushes per-cycle expectations from a
// timeline-based reference model, the monitor compares on the falling edge.
module tb_e_mdu;
   import e_mdu_pkg::*;

   typedef struct {
      bit          en;
      bit          busy;
      bit          stall;
      logic [31:0] out;
      string       tag;
   } exp_t;

   logic clk;
   logic rst;
   e_mdu_if bus();

   e_mdu dut (.clk(clk), .reset(rst), .mdu(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_mis = 0;

   // Reference model: architectural HI/LO plus the edge at which a pending
   // result becomes architectural.
   logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
   int          done_edge = 0;
   int          ne = 0;
   bit          model_ok = 0;

   function automatic void chk(string nm, string tag, logic [31:0] act, logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_mis++;
         $display("FAIL %s [%s] @%0t: got %h expected %h", nm, tag, $time, act, expv);
      end
   endfunction

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.en) begin
               chk("busy", e.tag, 32'(bus.busy), 32'(e.busy));
               chk("stall_req", e.tag, 32'(bus.stall_req), 32'(e.stall));
               chk("out", e.tag, bus.out, e.out);
            end
         end
      end
   end

   task automatic step(input bit r, input bit st, input logic [3:0] o,
                       input logic [31:0] av, input logic [31:0] bv, input string tag);
      exp_t e;
      bit busy_now;
      int e_next;
      longint sa, sb_v;
      longint unsigned ua, ub;
      logic [63:0] p;
      rst = r; bus.start = st; bus.op = o; bus.a = av; bus.b = bv;
      busy_now = (ne < done_edge);
      e.en    = model_ok;
      e.busy  = busy_now;
      e.stall = busy_now | st;
      e.out   = (o == MDU_MFHI) ? m_hi : (o == MDU_MFLO) ? m_lo : 32'd0;
      e.tag   = tag;
      sb.push_back(e);
      e_next = ne + 1;
      if (r) begin
         m_hi = 0; m_lo = 0; done_edge = 0; model_ok = 1;
      end else if (busy_now) begin
         if (e_next == done_edge) begin m_hi = m_phi; m_lo = m_plo; end
      end else if (st && (o >= MDU_MULT) && (o <= MDU_DIVU)) begin
         sa = longint'($signed(av)); sb_v = longint'($signed(bv));
         ua = {32'd0, av}; ub = {32'd0, bv};
         p = {m_hi, m_lo};
         case (o)
            MDU_MULT:  p = sa * sb_v;
            MDU_MULTU: p = ua * ub;
            MDU_DIV:   if (bv != 0) p = {32'(sa % sb_v), 32'(sa / sb_v)};
            default:   if (bv != 0) p = {32'(ua % ub), 32'(ua / ub)};
         endcase
         m_phi = p[63:32]; m_plo = p[31:0];
         done_edge = e_next + ((o <= MDU_MULTU) ? 5 : 10);
      end else if (o == MDU_MTHI) begin
         m_hi = av;
      end else if (o == MDU_MTLO) begin
         m_lo = av;
      end
      @(posedge clk); #1;
      ne++;
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++)
         step(0, 0, (i % 2) ? MDU_MFHI : MDU_MFLO, 32'd0, 32'd0, tag);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; bus.start = 0; bus.op = MDU_NONE; bus.a = 0; bus.b = 0;
      @(posedge clk); #1;

      step(1, 1, MDU_MULT, 32'd5, 32'd7, "reset");
      step(1, 1, MDU_MULT, 32'd5, 32'd7, "reset");
      step(0, 0, MDU_MFHI, 32'd0, 32'd0, "after_reset");
      step(0, 0, MDU_MFLO, 32'd0, 32'd0, "after_reset");

      step(0, 1, MDU_MULT, 32'hFFFF_FFFE, 32'd3, "mult");
      idle(6, "mult");
      step(0, 1, MDU_MULTU, 32'hFFFF_FFFE, 32'd3, "multu");
      idle(6, "multu");

      step(0, 1, MDU_DIV, 32'hFFFF_FFF9, 32'd2, "div");
      idle(11, "div");
      step(0, 1, MDU_DIVU, 32'd7, 32'd2, "divu");
      idle(11, "divu");

      step(0, 0, MDU_MTHI, 32'h11, 32'd0, "mthi");
      step(0, 0, MDU_MTLO, 32'h22, 32'd0, "mtlo");
      step(0, 1, MDU_DIV, 32'd9, 32'd0, "div0");
      idle(11, "div0");

      step(0, 1, MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      idle(11, "div_ovf");

      step(0, 1, MDU_DIV, 32'd100, 32'd7, "busy_mtlo");
      idle(7, "busy_mtlo");
      step(0, 0, MDU_MTLO, 32'hABCD, 32'd0, "busy_mtlo");
      step(0, 1, MDU_MULT, 32'd3, 32'd3, "busy_restart");
      idle(2, "busy_restart");
      step(0, 0, MDU_MTLO, 32'hABCD, 32'd0, "idle_mtlo");
      idle(2, "idle_mtlo");

      step(0, 1, MDU_DIV, 32'd50, 32'd3, "mid_reset");
      idle(6, "mid_reset");
      step(1, 0, MDU_MFLO, 32'd0, 32'd0, "mid_reset");
      idle(2, "mid_reset");
      step(0, 1, MDU_MULT, 32'd6, 32'd7, "mult_6x7");
      idle(7, "mult_6x7");

      for (int i = 0; i < 500; i++) begin
         bit r, st;
         logic [3:0] o;
         r  = ($urandom_range(0, 99) < 2);
         st = ($urandom_range(0, 2) == 0);
         o  = 4'($urandom_range(0, 8));
         step(r, st, o, pick(), pick(), "random");
      end
      idle(12, "drain");

      repeat (2) @(negedge clk);
      n_vec++;
      if (sb.size() != 0) begin
         n_mis++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
